regfile_alu_core: RTL and testbench
===================================

// Module: regfile_alu_core
// PURPOSE
//  Parametrised register file + ALU + data memory executing one instruction per handshake (multi-cycle FSM).
//  Sits between the decode/control stage and the PC/fetch logic.
//  Adds to the fixed 32x32 version: width/depth parameters, valid/ready handshake, signed compare, shifts, BNE,
//  an illegal-op flag and a real PC register.
// PARAMETERS
//  XLEN       32   datapath / register / PC width
//  NREGS      32   register count; power of 2; x0 hardwired to zero
//  MEM_DEPTH  256  data memory words; power of 2; word-addressed
// PORTS
//  clk        in   1               rising-edge clock
//  reset      in   1               asynchronous, active-high reset
//  in_valid   in   1               instruction present on op/rs1/rs2/rd/imm
//  in_ready   out  1               core can accept; high only in IDLE
//  op         in   4               0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLL,7 SRL,8 LW,9 SW,10 BEQ,11 BNE; 12-15 illegal
//  rs1,rs2,rd in   $clog2(NREGS)   register indices
//  imm        in   12              signed immediate, sign-extended to XLEN
//  rv1,rv2    out  XLEN            combinational read of regs[rs1]/regs[rs2] (debug/forward)
//  out_valid  out  1               one-cycle completion pulse
//  result     out  XLEN            ALU result / load data / effective address (SW) / branch target (branches)
//  illegal    out  1               qualifies out_valid: op was 12-15
//  pc         out  XLEN            program counter
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; all regs, pc, result = 0; out_valid = 0; illegal = 0; memory NOT cleared.
//  FSM IDLE->EXEC->(MEM)->WB->IDLE. in_ready = (state==IDLE).
//   IDLE: on in_valid&in_ready latch op/rs1/rs2/rd/imm and operands regs[rs1]/regs[rs2] -> EXEC.
//   EXEC: compute; LW/SW -> MEM; all other ops -> WB.
//   MEM:  addr = (a + sext(imm)) mod MEM_DEPTH. SW: mem[addr] <= b at edge leaving MEM. LW: capture mem[addr].
//   WB:   out_valid = 1 for exactly this cycle; result stable. At the edge leaving WB, regs[rd] is written
//         (ALU ops, LW; skipped if rd==0 or illegal) and pc is updated -> IDLE.
//  Latency (accept edge = E): ALU/branch/illegal out_valid in cycle E+2; LW/SW in E+3.
//   Next accept is possible no earlier than E+3 (ALU) / E+4 (mem).
//  Arithmetic (a, b = latched operands): all ops mod 2^XLEN; SUB = a-b; SLT = signed a<b ? 1 : 0;
//   SLL/SRL shift by b[$clog2(XLEN)-1:0]; SRL is logical.
//  Branch: taken if (BEQ & a==b) | (BNE & a!=b); target = pc + sext(imm).
//   pc <= taken ? target : pc+4 (all ops incl. illegal advance pc+4); pc wraps mod 2^XLEN.
//  Illegal: illegal = 1 with out_valid; no reg/mem write; result = 0.
//  Operands are latched at accept: writes to regs after accept do not affect the in-flight op.
//  rv1/rv2 show a written value from the cycle after the WB edge.
//  x0: writes ignored, always reads 0.
//  in_valid outside IDLE is ignored; the source must hold the instruction until in_ready.
//  Reset mid-operation: the op is aborted, no reg/mem write occurs, out_valid never pulses.
// TESTING
//  1 reset; ADD x3=x1+x2 with regs x1=5,x2=7 (loaded via LW) -> out_valid E+2, result=12, rv1(rs1=3)=12 after WB.
//  2 SUB x4=x1-x2 (5-7) -> result=32'hFFFFFFFE; SLT x5,x4,x1 -> 1; SRL x4 by 31 -> 1.
//  3 SW x2 to imm=-1 with x1=0 -> addr wraps to 255; LW from addr 255 -> 7, out_valid E+3.
//  4 BEQ equal, imm=-8, pc=16 -> pc=8, result=8; BNE equal -> pc+4; ADD with rd=0 -> x0 stays 0.
//  5 op=13 -> out_valid + illegal=1, no reg change, pc+=4; in_valid held during EXEC -> ignored, in_ready=0.
//  6 assert reset during MEM of SW -> memory word unchanged, regs=0, pc=0, in_ready=1 immediately.

Source files
------------

// File: rtl/regfile_alu_core.sv
// regfile_alu_core: parametrised register file, ALU and word-addressed data
// memory that executes one instruction per valid/ready handshake through a
// small IDLE -> EXEC -> (MEM) -> WB state machine and owns the program counter.
module regfile_alu_core #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               op,
    input  logic [$clog2(NREGS)-1:0] rs1,
    input  logic [$clog2(NREGS)-1:0] rs2,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [11:0]              imm,
    output logic [XLEN-1:0]          rv1,
    output logic [XLEN-1:0]          rv2,
    output logic                     out_valid,
    output logic [XLEN-1:0]          result,
    output logic                     illegal,
    output logic [XLEN-1:0]          pc
);

    localparam int RW  = $clog2(NREGS);
    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MEM  = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_LW  = 4'd8;
    localparam logic [3:0] OP_SW  = 4'd9;
    localparam logic [3:0] OP_BEQ = 4'd10;
    localparam logic [3:0] OP_BNE = 4'd11;

    logic [1:0]      state_q, state_d;
    logic [3:0]      op_q;
    logic [RW-1:0]   rd_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q;
    logic            taken_q, taken_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] mem_q  [MEM_DEPTH];

    logic            accept;
    logic            isMemOp;
    logic            writesReg;
    logic [XLEN-1:0] immExt;
    logic [AW-1:0]   memAddr;
    logic [XLEN-1:0] branchTarget;

    assign accept       = in_valid && (state_q == ST_IDLE);
    assign isMemOp      = (op_q == OP_LW) || (op_q == OP_SW);
    assign writesReg    = (op_q <= OP_LW) && (rd_q != '0);
    assign immExt       = {{(XLEN-12){imm[11]}}, imm};
    assign memAddr      = AW'(a_q + imm_q);
    assign branchTarget = pc_q + imm_q;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_WB);
    assign illegal   = illegal_q && (state_q == ST_WB);
    assign result    = result_q;
    assign pc        = pc_q;
    assign rv1       = (rs1 == '0) ? '0 : regs_q[rs1];
    assign rv2       = (rs2 == '0) ? '0 : regs_q[rs2];

    // Sequence the instruction: memory ops take the extra MEM step, everything else goes straight to WB
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = isMemOp ? ST_MEM : ST_WB;
            ST_MEM:  state_d = ST_WB;
            default: state_d = ST_IDLE;
        endcase
    end

    // Execute-stage result: ALU value, wrapped memory address for LW/SW, branch target, or zero if illegal
    always_comb begin
        result_d = '0;
        taken_d  = 1'b0;
        case (op_q)
            OP_ADD: result_d = a_q + b_q;
            OP_SUB: result_d = a_q - b_q;
            OP_AND: result_d = a_q & b_q;
            OP_OR:  result_d = a_q | b_q;
            OP_XOR: result_d = a_q ^ b_q;
            OP_SLT: result_d = ($signed(a_q) < $signed(b_q)) ? XLEN'(1) : '0;
            OP_SLL: result_d = a_q << b_q[SHW-1:0];
            OP_SRL: result_d = a_q >> b_q[SHW-1:0];
            OP_LW,
            OP_SW:  result_d = XLEN'(memAddr);
            OP_BEQ: begin
                result_d = branchTarget;
                taken_d  = (a_q == b_q);
            end
            OP_BNE: begin
                result_d = branchTarget;
                taken_d  = (a_q != b_q);
            end
            default: result_d = '0;
        endcase
    end

    // Core state: latch the instruction and its operands at accept, then update result, registers and pc
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            taken_q   <= 1'b0;
            pc_q      <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= op;
                        rd_q      <= rd;
                        imm_q     <= immExt;
                        a_q       <= rv1;
                        b_q       <= rv2;
                        illegal_q <= (op > OP_BNE);
                    end
                end
                ST_EXEC: begin
                    result_q <= result_d;
                    taken_q  <= taken_d;
                end
                ST_MEM: begin
                    if (op_q == OP_LW) result_q <= mem_q[memAddr];
                end
                default: begin
                    pc_q <= taken_q ? result_q : pc_q + XLEN'(4);
                    if (writesReg) regs_q[rd_q] <= result_q;
                end
            endcase
        end
    end

    // Data memory store; contents deliberately survive reset, and reset forces IDLE so an aborted SW never writes
    always_ff @(posedge clk) begin
        if ((state_q == ST_MEM) && (op_q == OP_SW)) mem_q[memAddr] <= b_q;
    end

endmodule

// File: tb/tb_regfile_alu_core.sv
// tb_regfile_alu_core: directed and randomized checks of regfile_alu_core
// against an instruction-level reference model held in plain arrays.
module tb_regfile_alu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm;
    logic [31:0] rv1, rv2;
    logic        out_valid;
    logic [31:0] result;
    logic        illegal;
    logic [31:0] pc;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mRegs [32];
    logic [31:0] mMem  [256];
    logic [31:0] mPc;

    bit          chkEn      = 1'b0;
    bit          expReady   = 1'b1;
    bit          expValid   = 1'b0;
    bit          expIllegal = 1'b0;
    logic [31:0] expResult  = '0;
    logic [31:0] gotResult;
    logic        gotIllegal;

    regfile_alu_core #(.XLEN(32), .NREGS(32), .MEM_DEPTH(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .rv1       (rv1),
        .rv2       (rv2),
        .out_valid (out_valid),
        .result    (result),
        .illegal   (illegal),
        .pc        (pc)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every observable output against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("in_ready", 32'(in_ready), 32'(expReady));
            checkOutput("out_valid", 32'(out_valid), 32'(expValid));
            if (expValid) begin
                checkOutput("result", result, expResult);
                checkOutput("illegal", 32'(illegal), 32'(expIllegal));
            end
            checkOutput("pc", pc, mPc);
            checkOutput("rv1", rv1, mRegs[rs1]);
            checkOutput("rv2", rv2, mRegs[rs2]);
        end
    end

    // Issue one instruction, compute its architectural effect from the instruction rules, and step the expectations
    task automatic applyStimulus(input logic [3:0] o, input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [4:0] d, input logic [11:0] im, input bit holdValid);
        logic [31:0] a, b, sx, res, nextPc;
        logic [7:0]  addr;
        bit          isMem, wr, ill;
        a      = mRegs[s1];
        b      = mRegs[s2];
        sx     = sext12(im);
        addr   = 8'((a + sx) % 256);
        isMem  = (o == 4'd8) || (o == 4'd9);
        ill    = (o >= 4'd12);
        wr     = (o <= 4'd8) && (d != 5'd0);
        nextPc = mPc + 32'd4;
        case (o)
            4'd0:  res = a + b;
            4'd1:  res = a - b;
            4'd2:  res = a & b;
            4'd3:  res = a | b;
            4'd4:  res = a ^ b;
            4'd5:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  res = a << (b % 32);
            4'd7:  res = a >> (b % 32);
            4'd8:  res = mMem[addr];
            4'd9:  res = 32'(addr);
            4'd10: begin res = mPc + sx; if (a == b) nextPc = res; end
            4'd11: begin res = mPc + sx; if (a != b) nextPc = res; end
            default: res = 32'd0;
        endcase

        op = o; rs1 = s1; rs2 = s2; rd = d; imm = im; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = holdValid;
        expReady = 1'b0;
        if (isMem) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        expValid   = 1'b1;
        expResult  = res;
        expIllegal = ill;
        gotResult  = result;
        gotIllegal = illegal;
        @(posedge clk); #1;
        expValid = 1'b0;
        expReady = 1'b1;
        if (wr) mRegs[d] = res;
        if (o == 4'd9) mMem[addr] = b;
        mPc = nextPc;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
        mPc = '0;
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        for (int i = 0; i < 256; i++) mMem[i] = $urandom;
        mMem[1] = 32'd5;
        mMem[2] = 32'd7;
        mMem[3] = 32'd31;
        mMem[10] = 32'h0000A5A5;
        mMem[255] = 32'h12345678;
        for (int i = 0; i < 256; i++) dut.mem_q[i] <= mMem[i];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset illegal", 32'(illegal), 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset pc", pc, 32'd0);
        reset = 1'b0;
        chkEn = 1'b1;

        // Load operands and exercise arithmetic
        applyStimulus(4'd8, 5'd0, 5'd0, 5'd1, 12'd1, 1'b0);
        checkOutput("lw x1", gotResult, 32'd5);
        applyStimulus(4'd8, 5'd0, 5'd0, 5'd2, 12'd2, 1'b0);
        applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 12'd0, 1'b0);
        checkOutput("add result", gotResult, 32'd12);
        rs1 = 5'd3; #1;
        checkOutput("add rv1 x3", rv1, 32'd12);
        applyStimulus(4'd1, 5'd1, 5'd2, 5'd4, 12'd0, 1'b0);
        checkOutput("sub result", gotResult, 32'hFFFFFFFE);
        checkOutput("pc before beq", pc, 32'd16);

        // Branches
        applyStimulus(4'd10, 5'd1, 5'd1, 5'd0, 12'hFF8, 1'b0);
        checkOutput("beq result", gotResult, 32'd8);
        checkOutput("beq pc", pc, 32'd8);
        applyStimulus(4'd11, 5'd1, 5'd1, 5'd0, 12'hFF8, 1'b0);
        checkOutput("bne pc", pc, 32'd12);

        // Signed compare and logical shift
        applyStimulus(4'd8, 5'd0, 5'd0, 5'd7, 12'd3, 1'b0);
        applyStimulus(4'd5, 5'd4, 5'd1, 5'd5, 12'd0, 1'b0);
        checkOutput("slt result", gotResult, 32'd1);
        applyStimulus(4'd7, 5'd4, 5'd7, 5'd6, 12'd0, 1'b0);
        checkOutput("srl result", gotResult, 32'd1);

        // Store with wrapped address and load back
        applyStimulus(4'd9, 5'd0, 5'd2, 5'd0, 12'hFFF, 1'b0);
        applyStimulus(4'd8, 5'd0, 5'd0, 5'd8, 12'hFFF, 1'b0);
        checkOutput("lw wrapped", gotResult, 32'd7);

        // x0 stays zero, illegal op with in_valid held while busy
        applyStimulus(4'd0, 5'd1, 5'd2, 5'd0, 12'd0, 1'b0);
        rs1 = 5'd0; #1;
        checkOutput("x0 read", rv1, 32'd0);
        applyStimulus(4'd13, 5'd1, 5'd2, 5'd3, 12'd0, 1'b1);
        checkOutput("illegal flag", 32'(gotIllegal), 32'd1);
        checkOutput("illegal result", gotResult, 32'd0);
        rs1 = 5'd3; #1;
        checkOutput("illegal keeps x3", rv1, 32'd12);

        // Reset asserted during the MEM step of a store
        op = 4'd9; rs1 = 5'd0; rs2 = 5'd2; rd = 5'd0; imm = 12'd10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        expReady = 1'b0;
        @(posedge clk); #1;
        chkEn = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("abort in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort pc", pc, 32'd0);
        checkOutput("abort out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort rv2 x2", rv2, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        mPc = '0;
        expReady = 1'b1;
        expValid = 1'b0;
        chkEn = 1'b1;
        applyStimulus(4'd8, 5'd0, 5'd0, 5'd9, 12'd10, 1'b0);
        checkOutput("abort mem kept", gotResult, 32'h0000A5A5);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), 12'($urandom), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        chkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
